pll_lock_ctrl: RTL and testbench



---
 rtl/pll_lock_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: brings up the PLL from the free-running reference clock.
// Pulses the PLL reset, waits for lock (with a timeout), qualifies the lock
// as stable, then releases the active-low system reset. Lock loss or timeout
// re-runs the sequence, with bounded retries, before parking in FAIL.
//
// Optional build macro: PLL_PWD_EN adds a PLL power-down request path
// (pwd_req in, pll_pwd out, PWD state). Without it the PWD state is
// unreachable, and the caller ties the PLL power-down pin low.
//
// Ports:
//   clk        free-running reference clock (same net as PLL clkin)
//   rst_n      asynchronous active-low reset
//   pll_lock   PLL lock, asynchronous to clk (synchronized internally)
//   restart    synchronous one-cycle request to restart the sequence
//   pwd_req    power-down request (PLL_PWD_EN only)
//   pll_pwd    PLL power-down (PLL_PWD_EN only)
//   pll_reset  active-high PLL reset
//   sys_rst_n  active-low system reset for downstream logic
//   locked     qualified lock status
//   fail       retries exhausted
//   retry_cnt  failed attempts in the current sequence
//   state      RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4, PWD=5
module pll_lock_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       restart,
`ifdef PLL_PWD_EN
  input  logic       pwd_req,
  output logic       pll_pwd,
`endif
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  localparam int unsigned MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] RST_TC    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_TC   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RST       = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4,
    S_PWD       = 3'd5
  } state_t;

  state_t           cur;
  logic [CNT_W-1:0] cnt;
  logic             lock_meta;
  logic             lock_s;
  logic             attempt_fail;

  assign state = cur;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // A WAIT_LOCK timeout and a lock drop during STABLE are the same event:
  // the current attempt failed.
  always_comb begin
    attempt_fail = 1'b0;
    if (cur == S_WAIT_LOCK && !lock_s && cnt == LOCK_TC)
      attempt_fail = 1'b1;
    if (cur == S_STABLE && !lock_s)
      attempt_fail = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= S_RST;
      cnt       <= '0;
      pll_reset <= 1'b1;
      sys_rst_n <= 1'b0;
      locked    <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
`ifdef PLL_PWD_EN
      pll_pwd   <= 1'b0;
`endif
    end else begin
`ifdef PLL_PWD_EN
      if (cur == S_PWD && pwd_req) begin
        // restart is masked while power-down stays requested
      end else
`endif
      if (restart) begin
        cur       <= S_RST;
        cnt       <= '0;
        pll_reset <= 1'b1;
        sys_rst_n <= 1'b0;
        locked    <= 1'b0;
        fail      <= 1'b0;
        retry_cnt <= '0;
`ifdef PLL_PWD_EN
        pll_pwd   <= 1'b0;
`endif
      end else if (attempt_fail) begin
        cnt       <= '0;
        pll_reset <= 1'b1;
        if (retry_cnt == RETRY_MAX) begin
          cur  <= S_FAIL;
          fail <= 1'b1;
        end else begin
          cur       <= S_RST;
          retry_cnt <= retry_cnt + 4'd1;
        end
      end else begin
        case (cur)
          S_RST: begin
            if (cnt == RST_TC) begin
              cur       <= S_WAIT_LOCK;
              cnt       <= '0;
              pll_reset <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          S_WAIT_LOCK: begin
            if (lock_s) begin
              cur <= S_STABLE;
              cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          S_STABLE: begin
            if (cnt == STABLE_TC) begin
              cur       <= S_RUN;
              cnt       <= '0;
              sys_rst_n <= 1'b1;
              locked    <= 1'b1;
              retry_cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          S_RUN: begin
`ifdef PLL_PWD_EN
            if (pwd_req) begin
              cur       <= S_PWD;
              cnt       <= '0;
              pll_pwd   <= 1'b1;
              pll_reset <= 1'b1;
              sys_rst_n <= 1'b0;
              locked    <= 1'b0;
              fail      <= 1'b0;
            end else
`endif
            if (!lock_s) begin
              // Lock loss starts a fresh sequence; retry_cnt is left alone.
              cur       <= S_RST;
              cnt       <= '0;
              pll_reset <= 1'b1;
              sys_rst_n <= 1'b0;
              locked    <= 1'b0;
            end
          end

          S_FAIL: begin
`ifdef PLL_PWD_EN
            if (pwd_req) begin
              cur       <= S_PWD;
              cnt       <= '0;
              pll_pwd   <= 1'b1;
              pll_reset <= 1'b1;
              sys_rst_n <= 1'b0;
              locked    <= 1'b0;
              fail      <= 1'b0;
            end
`endif
          end

          S_PWD: begin
            // Only reachable with pwd_req low here (held case handled above).
            cur       <= S_RST;
            cnt       <= '0;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
            retry_cnt <= '0;
`ifdef PLL_PWD_EN
            pll_pwd   <= 1'b0;
`endif
          end

          default: begin
            cur       <= S_RST;
            cnt       <= '0;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with RST_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8, MAX_RETRY=2. Expected outputs are queued with the cycle
// they are due and compared when that cycle is reached.
module tb_pll_lock_ctrl;

  localparam int unsigned RST_CYCLES    = 4;
  localparam int unsigned LOCK_TIMEOUT  = 20;
  localparam int unsigned STABLE_CYCLES = 8;
  localparam int unsigned MAX_RETRY     = 2;

  localparam logic [2:0] ST_RST    = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_STABLE = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_FAIL   = 3'd4;
`ifdef PLL_PWD_EN
  localparam logic [2:0] ST_PWD    = 3'd5;
`endif

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       pll_lock = 1'b0;
  logic       restart  = 1'b0;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       locked;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;
  logic       pwd_obs;

`ifdef PLL_PWD_EN
  logic pwd_req = 1'b0;
  logic pll_pwd;
  assign pwd_obs = pll_pwd;
`else
  assign pwd_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  pll_lock_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .restart  (restart),
`ifdef PLL_PWD_EN
    .pwd_req  (pwd_req),
    .pll_pwd  (pll_pwd),
`endif
    .pll_reset(pll_reset),
    .sys_rst_n(sys_rst_n),
    .locked   (locked),
    .fail     (fail),
    .retry_cnt(retry_cnt),
    .state    (state)
  );

  // {state, pll_reset, sys_rst_n, locked, fail, retry_cnt, pll_pwd}
  logic [11:0] obs;
  assign obs = {state, pll_reset, sys_rst_n, locked, fail, retry_cnt, pwd_obs};

  typedef struct {
    int unsigned due;
    string       tag;
    logic [11:0] exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc   = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic logic [11:0] mk(input logic [2:0] st, input logic pr, input logic sr,
                                     input logic lk, input logic fl, input logic [3:0] rc,
                                     input logic pw);
    return {st, pr, sr, lk, fl, rc, pw};
  endfunction

  task automatic expect_at(input int unsigned d, input string tag, input logic [11:0] e);
    exp_t it;
    it.due = cyc + d;
    it.tag = tag;
    it.exp = e;
    sb.push_back(it);
  endtask

  task automatic service();
    exp_t it;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      it = sb.pop_front();
      n_cmp++;
      assert (obs === it.exp) else begin
        n_bad++;
        $error("FAIL %s: observed %b required %b (cycle %0d)", it.tag, obs, it.exp, cyc);
      end
    end
  endtask

  task automatic advance(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      service();
    end
  endtask

  // Called right after the edge that leaves RST with counter 0; lock_s must
  // be high by the time WAIT_LOCK is entered.
  task automatic bringup(input string tag, input logic [3:0] rc);
    expect_at(1,  {tag, "_rst1"},    mk(ST_RST,    1'b1, 1'b0, 1'b0, 1'b0, rc,   1'b0));
    expect_at(3,  {tag, "_rst3"},    mk(ST_RST,    1'b1, 1'b0, 1'b0, 1'b0, rc,   1'b0));
    expect_at(4,  {tag, "_wait"},    mk(ST_WAIT,   1'b0, 1'b0, 1'b0, 1'b0, rc,   1'b0));
    expect_at(5,  {tag, "_stable"},  mk(ST_STABLE, 1'b0, 1'b0, 1'b0, 1'b0, rc,   1'b0));
    expect_at(12, {tag, "_stable7"}, mk(ST_STABLE, 1'b0, 1'b0, 1'b0, 1'b0, rc,   1'b0));
    expect_at(13, {tag, "_release"}, mk(ST_RUN,    1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0));
    expect_at(14, {tag, "_run"},     mk(ST_RUN,    1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0));
    advance(14);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then nominal bring-up with lock high throughout.
    pll_lock = 1'b1;
    advance(3);
    expect_at(0, "reset_state", mk(ST_RST, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    service();
    rst_n = 1'b1;
    bringup("nominal", 4'd0);

    // Lock loss in RUN: two sync stages, then one edge to leave RUN.
    pll_lock = 1'b0;
    expect_at(2, "lossrun_hold", mk(ST_RUN, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0));
    expect_at(3, "lossrun_rst",  mk(ST_RST, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    advance(3);
    pll_lock = 1'b1;
    bringup("reseq", 4'd0);

    // Late lock: rises 10 cycles into WAIT_LOCK.
    restart  = 1'b1;
    pll_lock = 1'b0;
    expect_at(1, "late_restart", mk(ST_RST, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    advance(1);
    restart = 1'b0;
    expect_at(4,  "late_wait",   mk(ST_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    expect_at(14, "late_wait10", mk(ST_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    advance(14);
    pll_lock = 1'b1;
    expect_at(2,  "late_sync",    mk(ST_WAIT,   1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    expect_at(3,  "late_stable",  mk(ST_STABLE, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    expect_at(10, "late_stable7", mk(ST_STABLE, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    expect_at(11, "late_release", mk(ST_RUN,    1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0));
    advance(11);

    // One-cycle lock glitch while STABLE count is 5.
    restart = 1'b1;
    expect_at(1, "glitch_restart", mk(ST_RST, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    advance(1);
    restart = 1'b0;
    expect_at(5, "glitch_stable", mk(ST_STABLE, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    advance(8);
    pll_lock = 1'b0;
    advance(1);
    pll_lock = 1'b1;
    expect_at(1, "glitch_cnt5",  mk(ST_STABLE, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    expect_at(2, "glitch_retry", mk(ST_RST,    1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0));
    advance(2);
    bringup("requal", 4'd1);

    // Timeouts: three attempts, then FAIL.
    restart  = 1'b1;
    pll_lock = 1'b0;
    expect_at(1, "to_restart", mk(ST_RST, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    advance(1);
    restart = 1'b0;
    expect_at(4,  "to_wait1",   mk(ST_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    expect_at(23, "to_wait1e",  mk(ST_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    expect_at(24, "to_retry1",  mk(ST_RST,  1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0));
    expect_at(27, "to_rst2",    mk(ST_RST,  1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0));
    expect_at(28, "to_wait2",   mk(ST_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0));
    expect_at(47, "to_wait2e",  mk(ST_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0));
    expect_at(48, "to_retry2",  mk(ST_RST,  1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0));
    expect_at(52, "to_wait3",   mk(ST_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0));
    expect_at(72, "to_fail",    mk(ST_FAIL, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0));
    expect_at(80, "to_failhold", mk(ST_FAIL, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0));
    advance(80);

    // Restart out of FAIL, held for three cycles.
    restart  = 1'b1;
    pll_lock = 1'b1;
    expect_at(1, "fail_restart", mk(ST_RST, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    expect_at(3, "restart_held", mk(ST_RST, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    advance(3);
    restart = 1'b0;
    bringup("after_fail", 4'd0);

    // Asynchronous reset in RUN: sys_rst_n must drop without waiting for an edge.
    rst_n = 1'b0;
    #1;
    expect_at(0, "async_run", mk(ST_RST, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    service();
    advance(2);
    rst_n = 1'b1;
    expect_at(5, "async_pre_stable", mk(ST_STABLE, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    advance(8);
    // Asynchronous reset mid-STABLE.
    rst_n = 1'b0;
    #1;
    expect_at(0, "async_stable", mk(ST_RST, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    service();
    advance(2);
    rst_n = 1'b1;
    bringup("after_async", 4'd0);

`ifdef PLL_PWD_EN
    // Power-down from RUN; restart is ignored while pwd_req stays high.
    pwd_req = 1'b1;
    expect_at(1, "pwd_enter", mk(ST_PWD, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
    advance(1);
    restart = 1'b1;
    expect_at(1, "pwd_masked", mk(ST_PWD, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
    advance(1);
    restart = 1'b0;
    pwd_req = 1'b0;
    expect_at(1, "pwd_exit", mk(ST_RST, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    advance(1);
    bringup("after_pwd", 4'd0);
`endif

    // Every queued expectation must have been consumed.
    n_cmp++;
    assert (sb.size() == 0) else begin
      n_bad++;
      $error("FAIL scoreboard_drain: observed %0d pending required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
